// File: rtl/mux_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin bus arbiter.
// Holds state encoding, requester count and the round-robin pick.
package mux_arb_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [1:0] rr_pick(
    input logic [3:0] req,
    input logic [1:0] last_owner
  );
    logic [1:0] idx;
    logic       found;
    rr_pick = last_owner;
    found   = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = last_owner + 2'(i);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/rr_priority_pick_4.sv
// Combinational round-robin pick over four requests.
// Scans upward from last_owner+1, wrapping; any_req flags a valid winner.
module rr_priority_pick_4
  import mux_arb_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last_owner,
  output logic [1:0] winner,
  output logic       any_req
);

  // rotate-and-encode lives in the package so other arbiters share it
  always_comb begin
    winner  = rr_pick(req, last_owner);
    any_req = |req;
  end

endmodule

// File: rtl/mux_bus_arbiter.sv
// Round-robin owner of a shared 4:1 32-bit mux with hold timeout.
// Optional ARB_LOCK_EN adds a lock input that suppresses the timeout.
module mux_bus_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       req,
`ifdef ARB_LOCK_EN
  input  logic             lock,
`endif
  output logic [3:0]       grant,
  output logic [1:0]       select,
  output logic             enable,
  output logic             busy,
  output logic [CNT_W-1:0] hold_cnt
);

  state_t             state, state_n;
  logic [1:0]         last_owner, last_n;
  logic [3:0]         grant_n;
  logic [1:0]         select_n;
  logic               enable_n;
  logic               busy_n;
  logic [CNT_W-1:0]   hold_n;
  logic [1:0]         winner;
  logic               any_req;
  logic               at_max;
  logic               lock_hold;

  rr_priority_pick_4 u_pick (
    .req        (req),
    .last_owner (last_owner),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign at_max = (hold_cnt == CNT_W'(MAX_HOLD - 1));

`ifdef ARB_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  // next state and next registered outputs
  always_comb begin
    state_n  = state;
    grant_n  = grant;
    select_n = select;
    enable_n = enable;
    busy_n   = busy;
    hold_n   = hold_cnt;
    last_n   = last_owner;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_n  = GRANT;
          grant_n  = 4'b0001 << winner;
          select_n = winner;
          enable_n = 1'b1;
          busy_n   = 1'b1;
          hold_n   = '0;
          last_n   = winner;
        end
      end
      GRANT: begin
        if (!req[last_owner] || (at_max && !lock_hold)) begin
          state_n  = IDLE;
          grant_n  = '0;
          enable_n = 1'b0;
          busy_n   = 1'b0;
          hold_n   = '0;
        end else if (!at_max) begin
          hold_n = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // state and output registers; last_owner=3 gives requester 0 first turn
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= '0;
      select     <= '0;
      enable     <= 1'b0;
      busy       <= 1'b0;
      hold_cnt   <= '0;
      last_owner <= 2'd3;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      select     <= select_n;
      enable     <= enable_n;
      busy       <= busy_n;
      hold_cnt   <= hold_n;
      last_owner <= last_n;
    end
  end

  a_grant_onehot: assert property (
    @(posedge clock) disable iff (reset) $onehot0(grant));
  a_enable_grant: assert property (
    @(posedge clock) disable iff (reset) enable == (|grant));
  a_select_grant: assert property (
    @(posedge clock) disable iff (reset) enable |-> grant[select]);

endmodule

// File: doc/mux_bus_arbiter.md
Name: mux_bus_arbiter

Overview:
- Round-robin arbiter that shares one 4:1 32-bit tri-state mux/bus among four requesters.
- Drives the mux `select[1:0]` and `enable` from the current owner, and returns a one-hot grant to each requester.
- Enforces a max-hold timeout and a one-cycle turnaround, so no two sources ever drive the bus on back-to-back owner changes.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one owner may keep `enable` high (legal range 2..256).
- CNT_W, 8, width of the hold counter; must satisfy 2**CNT_W >= MAX_HOLD.

Ports:
- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request per requester; held high for as long as the bus is wanted.
- grant  output  4  one-hot grant; all zero when no owner.
- select  output  2  mux select, equal to the owner index; holds its last value when idle.
- enable  output  1  mux output enable; high only while an owner is granted.
- busy  output  1  high in the GRANT state.
- hold_cnt  output  CNT_W  number of cycles the current owner has held the bus; 0 when idle.

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high) sets:
  - state = IDLE, grant = 0, select = 0, enable = 0, busy = 0, hold_cnt = 0.
  - internal last_owner = 3, so requester 0 has top priority after reset.
- FSM states: IDLE, GRANT.
- IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise pick the first asserted req scanning upward from last_owner+1, wrapping mod 4.
  - Next cycle: state = GRANT, grant = onehot(winner), select = winner, enable = 1, busy = 1, hold_cnt = 0, last_owner = winner.
  - Request-to-grant latency is 1 cycle.
- GRANT:
  - If req[owner] == 0: go to IDLE next cycle with grant = 0, enable = 0, hold_cnt = 0.
  - Else if hold_cnt == MAX_HOLD-1: forced release to IDLE with the same output values. The owner becomes lowest priority through last_owner.
  - Else stay in GRANT and increment hold_cnt.
  - Requests from non-owners are ignored while in GRANT.
- Turnaround: every exit from GRANT passes through at least one IDLE cycle with enable = 0. Minimum owner-to-owner gap is 1 cycle.
- Sole requester: if the released owner is the only one still requesting, it is re-granted after the 1-cycle IDLE gap.
- Simultaneous requests: resolved purely by round-robin order from last_owner+1. Example: last_owner = 1 and req = 4'b1001 → winner 3.
- req[owner] dropping on the same cycle that hold_cnt reaches MAX_HOLD-1: treated as a normal release; the outcome is identical.
- Reset asserted mid-grant: enable goes to 0 on the next edge, with no partial cycle; last_owner returns to 3.
- Invariants (checked with assertions):
  - $onehot0(grant).
  - enable == |grant.
  - When enable = 1, grant[select] == 1.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds port `lock  input  1`, sampled only in GRANT.
  - While lock = 1 and req[owner] = 1, the MAX_HOLD forced release is suppressed and hold_cnt saturates at MAX_HOLD-1.
  - Release occurs only when req[owner] drops.
- Undefined: no lock port; the timeout always applies.

Decomposition:
- Package mux_arb_pkg:
  - State encoding localparams: IDLE = 1'b0, GRANT = 1'b1.
  - NUM_REQ = 4.
  - Function rr_pick(req, last_owner) returning the 2-bit winner index.
- One sub-module, rr_priority_pick_4: combinational rotate/priority-encode producing winner[1:0] and any_req. It is reused by later arbiters.
- The FSM, counter and output registers stay in mux_bus_arbiter.
- The integration wrapper connects select/enable directly to the existing 4:1 32-bit mux.

Test Plan:
- Reset: hold reset 3 cycles with req = 4'b1111 → grant = 0, enable = 0, select = 0; first grant after reset release is grant = 4'b0001, select = 0.
- Round robin: req = 4'b1111 constant, MAX_HOLD = 4 → grants cycle 0,1,2,3,0; each holds 4 cycles, separated by 1 cycle with enable = 0.
- Early release: grant req[2] alone, drop it after 2 cycles → enable falls 1 cycle later, hold_cnt returns to 0, grant = 0.
- Sole requester timeout: req = 4'b0100 held 20 cycles, MAX_HOLD = 16 → enable high 16 cycles, low 1 cycle, then re-granted to 2.
- Priority rotation: last_owner = 1, req = 4'b1001 → grant = 4'b1000; next arbitration with the same req → grant = 4'b0001.
- Mid-grant reset and lock: assert reset during a hold → enable = 0 at the next edge. With ARB_LOCK_EN, lock = 1 for 30 cycles → no forced release and hold_cnt stays at 15.
